thiele_coproc_arbiter: RTL

//  Shares one external coprocessor channel between the CPU's logic-engine port
//  (logic_req/ack) and Python-execution port (py_req/ack). Serialises requests,

---
 rtl/thiele_coproc_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/thiele_coproc_arbiter.sv
// thiele_coproc_arbiter: round-robin share of one coprocessor channel between the logic and Python ports
// One transaction in flight; a timeout substitutes TIMEOUT_DATA for a missing cop_ack.
module thiele_coproc_arbiter #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_0000,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             logic_req,
  input  logic [31:0]      logic_addr,
  output logic             logic_ack,
  output logic [31:0]      logic_data,
  input  logic             py_req,
  input  logic [31:0]      py_code_addr,
  output logic             py_ack,
  output logic [31:0]      py_result,
  output logic             cop_req,
  output logic             cop_sel,
  output logic [31:0]      cop_addr,
  input  logic             cop_ack,
  input  logic [31:0]      cop_data,
  output logic             busy,
  output logic             timeout_pulse,
  output logic [CNT_W-1:0] timeout_count
);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic armed_logic, armed_py, rr_next, to_flag;
  logic [31:0] resp_data;
  logic [WAIT_W-1:0] wait_cnt;
  logic el_l, el_p, grant_py;
  always_comb begin
    el_l = logic_req & armed_logic;
    el_p = py_req & armed_py;
    grant_py = el_p & (~el_l | rr_next);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      armed_logic   <= 1'b1;
      armed_py      <= 1'b1;
      rr_next       <= 1'b0;
      to_flag       <= 1'b0;
      resp_data     <= '0;
      wait_cnt      <= '0;
      logic_ack     <= 1'b0;
      logic_data    <= '0;
      py_ack        <= 1'b0;
      py_result     <= '0;
      cop_req       <= 1'b0;
      cop_sel       <= 1'b0;
      cop_addr      <= '0;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
      timeout_count <= '0;
    end else begin
      logic_ack     <= 1'b0;
      py_ack        <= 1'b0;
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: if (el_l | el_p) begin
          state    <= WAIT;
          cop_req  <= 1'b1;
          busy     <= 1'b1;
          cop_sel  <= grant_py;
          cop_addr <= grant_py ? py_code_addr : logic_addr;
          wait_cnt <= '0;
          to_flag  <= 1'b0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (cop_ack) begin
            resp_data <= cop_data;
            cop_req   <= 1'b0;
            state     <= RESP;
          end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            resp_data <= TIMEOUT_DATA;
            to_flag   <= 1'b1;
            cop_req   <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          state         <= IDLE;
          busy          <= 1'b0;
          timeout_pulse <= to_flag;
          rr_next       <= ~cop_sel;
          if (to_flag && !(&timeout_count)) timeout_count <= timeout_count + 1'b1;
          if (cop_sel) begin
            py_ack    <= 1'b1;
            py_result <= resp_data;
            armed_py  <= 1'b0;
          end else begin
            logic_ack   <= 1'b1;
            logic_data  <= resp_data;
            armed_logic <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      // a low request on any edge re-arms its port, overriding the disarm above
      if (!logic_req) armed_logic <= 1'b1;
      if (!py_req) armed_py <= 1'b1;
    end
  end
endmodule
